uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Function : 8N1 serial receiver with a one-byte holding register and sticky
//            framing-error / overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd,
   output logic [7:0] data,
   output logic       ready,
   output logic       ferr,
   output logic       overrun
);

   localparam int              c_CW      = $clog2(CLKS_PER_BIT);
   localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_WAITHI = 3'd4
   } state_t;

   state_t          r_state;
   logic [c_CW-1:0] r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_sync1;
   logic            r_sync2;
   logic [7:0]      r_data;
   logic            r_ready;
   logic            r_ferr;
   logic            r_overrun;

   logic            w_rxs;
   logic            w_stop_done;
   logic            w_load;
   logic            w_frame_err;

   assign w_rxs       = r_sync2;
   assign w_stop_done = (r_state == S_STOP) && (r_cnt == c_FULL_M1);
   assign w_load      = w_stop_done && w_rxs;
   assign w_frame_err = w_stop_done && !w_rxs;

   assign data    = r_data;
   assign ready   = r_ready;
   assign ferr    = r_ferr;
   assign overrun = r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_data    <= 8'h00;
         r_ready   <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;

         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            S_START: begin
               if (r_cnt == c_HALF_M1) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= w_rxs ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_cnt == c_FULL_M1) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= w_rxs;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_cnt == c_FULL_M1) begin
                  r_cnt   <= '0;
                  r_state <= w_rxs ? S_IDLE : S_WAITHI;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            S_WAITHI: begin
               if (w_rxs) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A consumer read on the load cycle frees the register for the new byte.
         if (w_load) begin
            if (r_ready && !rd) begin
               r_overrun <= 1'b1;
            end else begin
               r_data  <= r_shift;
               r_ready <= 1'b1;
               if (rd) begin
                  r_ferr    <= 1'b0;
                  r_overrun <= 1'b0;
               end
            end
         end else if (w_frame_err) begin
            r_ferr <= 1'b1;
            if (rd) begin
               r_ready   <= 1'b0;
               r_overrun <= 1'b0;
            end
         end else if (rd) begin
            r_ready   <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for uart_rx: frame-level reference model (event queue keyed by
// cycle number) compared every cycle, plus literal checks of key scenarios.
module tb_uart_rx;

   localparam int CPB  = 16;
   // rxd falls after posedge k; two synchronizer flops put it on the FSM input
   // for the sample at k+3, then half a bit plus nine full bits to the stop sample.
   localparam int LAT  = 3 + CPB / 2 + 9 * CPB;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rxd   = 1'b1;
   logic       rd    = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic       ferr;
   logic       overrun;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .rxd     (rxd),
      .rd      (rd),
      .data    (data),
      .ready   (ready),
      .ferr    (ferr),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      bit         fe;
      logic [7:0] b;
   } ev_t;

   ev_t        evq[$];
   ev_t        cur_ev;
   ev_t        new_ev;
   int         cyc        = 0;
   int         rd_at      = -100;
   bit         rand_rd    = 1'b0;
   bit         model_live = 1'b0;
   int         n_cmp      = 0;
   int         n_bad      = 0;
   int         start_k    = 0;
   int         rise_cyc   = -1;
   logic       prev_ready = 1'b0;

   logic [7:0] m_data;
   logic       m_ready;
   logic       m_ferr;
   logic       m_ovr;

   // Model update on each rising edge, then compare just after it.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (reset) begin
            m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            evq.delete();
            model_live = 1'b1;
         end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
            cur_ev = evq.pop_front();
            if (cur_ev.fe) begin
               m_ferr = 1'b1;
               if (rd) begin m_ready = 1'b0; m_ovr = 1'b0; end
            end else if (m_ready && !rd) begin
               m_ovr = 1'b1;
            end else begin
               m_data  = cur_ev.b;
               m_ready = 1'b1;
               if (rd) begin m_ferr = 1'b0; m_ovr = 1'b0; end
            end
         end else if (rd) begin
            m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         end
         #1;
         if (model_live) begin
            n_cmp = n_cmp + 4;
            if (data !== m_data) begin
               n_bad++;
               $display("FAIL model_data cyc=%0d got %h expected %h", cyc, data, m_data);
            end
            if (ready !== m_ready) begin
               n_bad++;
               $display("FAIL model_ready cyc=%0d got %b expected %b", cyc, ready, m_ready);
            end
            if (ferr !== m_ferr) begin
               n_bad++;
               $display("FAIL model_ferr cyc=%0d got %b expected %b", cyc, ferr, m_ferr);
            end
            if (overrun !== m_ovr) begin
               n_bad++;
               $display("FAIL model_overrun cyc=%0d got %b expected %b", cyc, overrun, m_ovr);
            end
            if (!prev_ready && ready === 1'b1) rise_cyc = cyc;
            prev_ready = (ready === 1'b1);
         end
      end
   end

   // Sole driver of rd: scheduled pulses plus optional random traffic.
   initial begin
      forever begin
         @(negedge clk);
         rd = (cyc + 1 == rd_at) || (rand_rd && $urandom_range(0, 23) == 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic glitch(input int g);
      @(negedge clk);
      rxd = 1'b0;
      repeat (g - 1) @(negedge clk);
      @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic pulse_rd();
      rd_at = cyc + 2;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int stop_low,
                             input bit rd_on_ev, input int rst_bit);
      @(negedge clk);
      start_k    = cyc;
      new_ev.cyc = cyc + LAT;
      new_ev.fe  = (stop_low > 0);
      new_ev.b   = b;
      evq.push_back(new_ev);
      if (rd_on_ev) rd_at = cyc + LAT;
      rxd = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rxd = b[i];
         if (i == rst_bit) begin
            repeat (4) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (CPB - 6) @(negedge clk);
         end else begin
            repeat (CPB - 1) @(negedge clk);
         end
      end
      if (stop_low > 0) begin
         @(negedge clk);
         rxd = 1'b0;
         repeat (stop_low * CPB - 1) @(negedge clk);
      end
      @(negedge clk);
      rxd = 1'b1;
      repeat (CPB - 1) @(negedge clk);
   endtask

   initial begin
      int kind;
      int gap;
      int slow;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_data", data, 8'h00);
      chk("reset_ready", ready, 1'b0);
      chk("reset_ferr", ferr, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      idle(20);

      // Single byte and its latency from the falling rxd edge.
      send_frame(8'hA5, 0, 1'b0, -1);
      chk("a5_latency", rise_cyc - start_k, 2 + CPB / 2 + 9 * CPB + 1);
      chk("a5_data", data, 8'hA5);
      chk("a5_ready", ready, 1'b1);
      chk("a5_flags", {ferr, overrun}, 2'b00);
      pulse_rd();

      // Back-to-back frames with no read: second byte is dropped.
      send_frame(8'h3C, 0, 1'b0, -1);
      send_frame(8'h81, 0, 1'b0, -1);
      chk("ovr_data", data, 8'h3C);
      chk("ovr_ready", ready, 1'b1);
      chk("ovr_overrun", overrun, 1'b1);
      pulse_rd();
      chk("ovr_rd_ready", ready, 1'b0);
      chk("ovr_rd_overrun", overrun, 1'b0);

      // Framing error coinciding with a read: the set wins.
      send_frame(8'h55, 3, 1'b1, -1);
      chk("fe_ferr", ferr, 1'b1);
      chk("fe_ready", ready, 1'b0);
      chk("fe_data", data, 8'h3C);
      idle(20);
      send_frame(8'h12, 0, 1'b0, -1);
      chk("after_fe_data", data, 8'h12);
      chk("after_fe_ready", ready, 1'b1);
      pulse_rd();
      chk("after_fe_rd_ferr", ferr, 1'b0);

      glitch(4);
      idle(40);
      chk("glitch_ready", ready, 1'b0);
      chk("glitch_ferr", ferr, 1'b0);
      chk("glitch_data", data, 8'h12);

      // Read on the exact load cycle of the second byte.
      send_frame(8'h11, 0, 1'b0, -1);
      send_frame(8'h7E, 0, 1'b1, -1);
      chk("rdload_data", data, 8'h7E);
      chk("rdload_ready", ready, 1'b1);
      chk("rdload_overrun", overrun, 1'b0);

      // Reset in the middle of data bit 4 aborts the frame.
      send_frame(8'hF0, 0, 1'b0, 4);
      idle(20);
      chk("midrst_data", data, 8'h00);
      chk("midrst_ready", ready, 1'b0);
      chk("midrst_flags", {ferr, overrun}, 2'b00);
      send_frame(8'h0F, 0, 1'b0, -1);
      chk("post_rst_data", data, 8'h0F);
      chk("post_rst_ready", ready, 1'b1);

      // Randomised traffic: gaps, glitches, framing errors, random reads.
      rand_rd = 1'b1;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         gap  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
         slow = (kind == 1) ? $urandom_range(1, 3) : 0;
         if (gap > 0) idle(gap);
         if (kind == 0) begin
            glitch($urandom_range(1, CPB / 2 - 2));
            idle(CPB / 2 + 4);
         end
         send_frame(8'($urandom), slow, 1'b0, -1);
      end
      rand_rd = 1'b0;
      idle(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
